// File: rtl/input_snapshot_sched.sv
// Per-frame input snapshot: captures all player inputs at vblank into a
// double-buffered bank and serves them to the CPU. Optional: INPUT_SNAPSHOT_CHANGE_IRQ_EN.
//
// state   | meaning
// IDLE    | waiting for a vblank rising edge
// CAPTURE | writing one player slot per cycle into the inactive bank
// SWAP    | flip the active bank, bump frame_count
module input_snapshot_sched #(
   parameter int PLAYERS = 6,
   parameter int SPIN_W  = 16
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   vblank,
   input  logic [32*PLAYERS-1:0]  joystick,
   input  logic [16*PLAYERS-1:0]  analog,
   input  logic [8*PLAYERS-1:0]   paddle,
   input  logic [16*PLAYERS-1:0]  spinner,
   input  logic                   cpu_rd_req,
   input  logic [4:0]             cpu_addr,
   output logic                   cpu_rd_ack,
   output logic [31:0]            cpu_dout,
   output logic [15:0]            frame_count,
   output logic                   busy
`ifdef INPUT_SNAPSHOT_CHANGE_IRQ_EN
   ,
   output logic                   change_irq
`endif
);

   localparam int IDX_W = 3;
   localparam logic [IDX_W-1:0] NUM_P    = IDX_W'(PLAYERS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PLAYERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SWAP} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic              vblank_q;
   logic              vb_edge;
   logic              bank_sel;
   logic              overrun;
   logic              rd_sample;
   logic              status_rd;
   logic [31:0]       rd_data;
   logic [2:0]        slot;
   logic [1:0]        field;

   logic [31:0]       joy_in   [PLAYERS];
   logic [15:0]       ana_in   [PLAYERS];
   logic [7:0]        pad_in   [PLAYERS];

   logic [31:0]       bank_joy  [2][PLAYERS];
   logic [15:0]       bank_ana  [2][PLAYERS];
   logic [7:0]        bank_pad  [2][PLAYERS];
   logic [SPIN_W-1:0] bank_spin [2][PLAYERS];

   logic [SPIN_W-1:0] spin_pos  [PLAYERS];
   logic [SPIN_W-1:0] spin_nxt  [PLAYERS];
   logic [PLAYERS-1:0] tog_q;
   logic              spin_unused;

   always_comb begin
      spin_unused = 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
         joy_in[p]   = joystick[32*p +: 32];
         ana_in[p]   = analog[16*p +: 16];
         pad_in[p]   = paddle[8*p +: 8];
         spin_unused = spin_unused ^ (^spinner[16*p+9 +: 7]);
         spin_nxt[p] = spin_pos[p];
         if (spinner[16*p+8] != tog_q[p])
            spin_nxt[p] = spin_pos[p] + {{(SPIN_W-8){spinner[16*p+7]}}, spinner[16*p +: 8]};
      end
   end

   // Spinner accumulators run in every state so no toggle is ever missed.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         tog_q <= '0;
         for (int p = 0; p < PLAYERS; p++) spin_pos[p] <= '0;
      end else begin
         for (int p = 0; p < PLAYERS; p++) begin
            spin_pos[p] <= spin_nxt[p];
            tog_q[p]    <= spinner[16*p+8];
         end
      end
   end

   assign vb_edge = vblank & ~vblank_q;
   assign busy    = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         S_IDLE: begin
            if (vb_edge) begin
               state_nxt = S_CAPTURE;
               idx_nxt   = '0;
            end
         end
         S_CAPTURE: begin
            if (idx == LAST_IDX) state_nxt = S_SWAP;
            else                 idx_nxt   = idx + 3'd1;
         end
         S_SWAP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Capture writes only the inactive bank; the CPU never sees a partial frame.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < PLAYERS; p++) begin
               bank_joy[b][p]  <= '0;
               bank_ana[b][p]  <= '0;
               bank_pad[b][p]  <= '0;
               bank_spin[b][p] <= '0;
            end
         end
      end else if (state == S_CAPTURE) begin
         bank_joy[~bank_sel][idx]  <= joy_in[idx];
         bank_ana[~bank_sel][idx]  <= ana_in[idx];
         bank_pad[~bank_sel][idx]  <= pad_in[idx];
         bank_spin[~bank_sel][idx] <= spin_nxt[idx];
      end
   end

   assign slot      = cpu_addr[4:2];
   assign field     = cpu_addr[1:0];
   assign rd_sample = cpu_rd_req && (state != S_SWAP);
   assign status_rd = rd_sample && (cpu_addr == 5'b111_00);

`ifdef INPUT_SNAPSHOT_CHANGE_IRQ_EN
   logic irq_pending;
   logic diff_seen;
   logic irq_rd;

   assign irq_rd     = rd_sample && (cpu_addr == 5'b111_01);
   assign change_irq = irq_pending;

   // Differences are gathered during capture and published only at the swap.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         diff_seen   <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         if (state == S_SWAP)
            diff_seen <= 1'b0;
         else if (state == S_CAPTURE && joy_in[idx] != bank_joy[bank_sel][idx])
            diff_seen <= 1'b1;

         if (state == S_SWAP && diff_seen) irq_pending <= 1'b1;
         else if (irq_rd)                  irq_pending <= 1'b0;
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      if (slot < NUM_P) begin
         case (field)
            2'd0:    rd_data = bank_joy[bank_sel][slot];
            2'd1:    rd_data = {bank_ana[bank_sel][slot], bank_pad[bank_sel][slot], 8'h00};
            2'd2:    rd_data = 32'(bank_spin[bank_sel][slot]);
            default: rd_data = {frame_count, 16'h0000};
         endcase
      end else if (slot == 3'd7) begin
         if (field == 2'd0)
            rd_data = {busy, overrun, 14'b0, frame_count};
`ifdef INPUT_SNAPSHOT_CHANGE_IRQ_EN
         else if (field == 2'd1)
            rd_data = {31'b0, irq_pending};
`endif
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         vblank_q    <= 1'b0;
         bank_sel    <= 1'b0;
         frame_count <= '0;
         overrun     <= 1'b0;
         cpu_rd_ack  <= 1'b0;
         cpu_dout    <= '0;
      end else begin
         vblank_q   <= vblank;
         cpu_rd_ack <= rd_sample;
         if (rd_sample) cpu_dout <= rd_data;
         if (state == S_SWAP) begin
            bank_sel    <= ~bank_sel;
            frame_count <= frame_count + 16'd1;
         end
         // A new overrun in the same cycle as the clearing read must survive.
         if (vb_edge && state != S_IDLE) overrun <= 1'b1;
         else if (status_rd)             overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_input_snapshot_sched.sv
// Scoreboarded bench for input_snapshot_sched: reads push expected data,
// a negedge monitor pops and compares on every cpu_rd_ack.
module tb_input_snapshot_sched;

   localparam int PLAYERS = 6;

   logic                  clk_sys = 1'b0;
   logic                  reset   = 1'b1;
   logic                  vblank  = 1'b0;
   logic [32*PLAYERS-1:0] joystick = '0;
   logic [16*PLAYERS-1:0] analog   = '0;
   logic [8*PLAYERS-1:0]  paddle   = '0;
   logic [16*PLAYERS-1:0] spinner  = '0;
   logic                  cpu_rd_req = 1'b0;
   logic [4:0]            cpu_addr   = '0;
   logic                  cpu_rd_ack;
   logic [31:0]           cpu_dout;
   logic [15:0]           frame_count;
   logic                  busy;
`ifdef INPUT_SNAPSHOT_CHANGE_IRQ_EN
   logic                  change_irq;
`endif

   int checks   = 0;
   int failures = 0;
   int busy_cnt;
   logic [31:0] exp_q [$];

   always #5 clk_sys = ~clk_sys;

   input_snapshot_sched #(.PLAYERS(PLAYERS), .SPIN_W(16)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .vblank      (vblank),
      .joystick    (joystick),
      .analog      (analog),
      .paddle      (paddle),
      .spinner     (spinner),
      .cpu_rd_req  (cpu_rd_req),
      .cpu_addr    (cpu_addr),
      .cpu_rd_ack  (cpu_rd_ack),
      .cpu_dout    (cpu_dout),
      .frame_count (frame_count),
      .busy        (busy)
`ifdef INPUT_SNAPSHOT_CHANGE_IRQ_EN
      ,
      .change_irq  (change_irq)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (!reset && cpu_rd_ack) begin
         if (exp_q.size() == 0) check("ack_without_request", {31'b0, cpu_rd_ack}, 32'h0);
         else                   check("read_data", cpu_dout, exp_q.pop_front());
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] e);
      cpu_addr   = a;
      cpu_rd_req = 1'b1;
      exp_q.push_back(e);
      tick();
      cpu_rd_req = 1'b0;
      tick(2);
   endtask

   task automatic frame();
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick(10);
   endtask

   initial begin
      // reset in the middle of a capture
      tick(2);
      reset = 1'b0;
      tick(2);
      joystick[31:0] = 32'h0000_00AA;
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick(3);
      check("busy_mid_capture", {31'b0, busy}, 32'h1);
      reset = 1'b1;
      #1;
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_frame_count", {16'h0, frame_count}, 32'h0);
      check("reset_ack", {31'b0, cpu_rd_ack}, 32'h0);
      check("reset_dout", cpu_dout, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      rd(5'd0, 32'h0);
      check("frame_count_after_reset", {16'h0, frame_count}, 32'h0);

      // capture and swap
      joystick[31:0] = 32'h0000_0015;
      paddle[23:16]  = 8'h80;
      analog[15:0]   = 16'h1234;
      vblank   = 1'b1;
      busy_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) vblank = 1'b0;
         if (busy) busy_cnt++;
      end
      check("busy_cycles", busy_cnt, 32'd7);
      check("frame_count_1", {16'h0, frame_count}, 32'h1);
      rd(5'd0, 32'h0000_0015);
      rd(5'd9, 32'h0000_8000);
      rd(5'd1, 32'h1234_0000);

      // spinner: +5, +5, -3 then -8
      spinner[31:16] = 16'h0105;
      tick();
      spinner[31:16] = 16'h0005;
      tick();
      spinner[31:16] = 16'h01FD;
      tick();
      frame();
      rd(5'd6, 32'h0000_0007);
      check("frame_count_2", {16'h0, frame_count}, 32'h2);
      spinner[31:16] = 16'h00F8;
      tick();
      frame();
      rd(5'd6, 32'h0000_FFFF);
      check("frame_count_3", {16'h0, frame_count}, 32'h3);

      // coherency: continuous read across a capture with joystick changing
      joystick[31:0] = 32'h1;
      frame();
      cpu_addr   = 5'd0;
      cpu_rd_req = 1'b1;
      vblank     = 1'b1;
      for (int i = 0; i < 7; i++) exp_q.push_back(32'h1);
      exp_q.push_back(32'h2);
      exp_q.push_back(32'h2);
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            vblank = 1'b0;
            joystick[31:0] = 32'h2;
         end
         if (k == 8) check("no_ack_after_swap_sample", {31'b0, cpu_rd_ack}, 32'h0);
      end
      cpu_rd_req = 1'b0;
      tick(2);
      check("frame_count_5", {16'h0, frame_count}, 32'h5);

      // overrun: second edge 3 cycles into capture
      vblank = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (k == 1) vblank = 1'b0;
         if (k == 3) vblank = 1'b1;
         if (k == 4) vblank = 1'b0;
      end
      check("frame_count_6", {16'h0, frame_count}, 32'h6);
      cpu_addr   = 5'd28;
      cpu_rd_req = 1'b1;
      exp_q.push_back(32'h4000_0006);
      exp_q.push_back(32'h0000_0006);
      tick(2);
      cpu_rd_req = 1'b0;
      tick(2);
      rd(5'd3,  32'h0006_0000);
      rd(5'd24, 32'h0);
      rd(5'd2,  32'h0);
`ifndef INPUT_SNAPSHOT_CHANGE_IRQ_EN
      rd(5'd29, 32'h0);
`else
      // irq: earlier joystick0 changes already left one pending
      rd(5'd29, 32'h1);
      check("irq_cleared", {31'b0, change_irq}, 32'h0);
      joystick[100] = 1'b1;
      frame();
      check("irq_raised", {31'b0, change_irq}, 32'h1);
      rd(5'd29, 32'h1);
      check("irq_dropped", {31'b0, change_irq}, 32'h0);
      frame();
      check("irq_identical_frame", {31'b0, change_irq}, 32'h0);
      rd(5'd29, 32'h0);
`endif

      tick(2);
      check("pending_reads", exp_q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/input_snapshot_sched.md
Name: input_snapshot_sched

Overview:
- Samples all six player input sets (digital, analog, paddle, spinner) once per frame at vblank start.
- Writes them into a double-buffered snapshot and serves them to the system CPU through a one-outstanding-read request/ack port.
- Runs continuous spinner accumulation so spinner events between frames are never lost.
- Sits between hps_io outputs and the system core's input-port address decode.

Parameters:
- PLAYERS, 6, number of player slots captured (1..7; slot 7 is reserved for status).
- SPIN_W, 16, width of each spinner position accumulator.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous active-high reset
- vblank  in  1  video vertical blank, synchronous to clk_sys
- joystick  in  32*PLAYERS  digital buttons, player 0 in the LSBs
- analog  in  16*PLAYERS  {Y[15:8], X[7:0]} signed per player
- paddle  in  8*PLAYERS  unsigned paddle per player
- spinner  in  16*PLAYERS  per player {7'b0, toggle[8], delta[7:0] signed}
- cpu_rd_req  in  1  read request pulse/level
- cpu_addr  in  5  {slot[2:0], field[1:0]}
- cpu_rd_ack  out  1  one-cycle data-valid strobe
- cpu_dout  out  32  read data
- frame_count  out  16  completed snapshot count
- busy  out  1  high during CAPTURE and SWAP

Behaviour:
- Reset (async): all outputs 0, bank select = 0, both banks zero, accumulators 0, overrun = 0, FSM = IDLE.
- Spinner accumulator, every cycle, all players:
  - If toggle differs from its registered previous value, pos <= pos + sign-extend(delta), wrapping modulo 2^SPIN_W.
  - The previous-toggle register loads on every cycle.
  - Accumulation continues in all FSM states.
- vblank rising edge (vblank registered; edge = vblank & ~vblank_q):
  - In IDLE: go to CAPTURE with idx = 0.
  - In CAPTURE or SWAP: ignored, overrun set sticky.
- CAPTURE: one player per cycle. Write joystick, analog, paddle and the current accumulator value (including that cycle's update) for slot idx into the inactive bank. idx++; after idx = PLAYERS-1, go to SWAP. Duration is exactly PLAYERS cycles.
- SWAP (1 cycle): bank select toggles, frame_count++ (wraps at 0xFFFF→0), then IDLE.
- Read port:
  - cpu_rd_req is sampled in any state except SWAP.
  - cpu_rd_ack = 1 and cpu_dout valid exactly 1 cycle after the sample.
  - A request held high during SWAP is sampled the next cycle, so ack is delayed by one.
  - Holding req high gives one ack every cycle; each sample is one read.
  - Reads always come from the active bank and never see partially captured data.
- Field map, slot < PLAYERS:
  - 0 = joystick
  - 1 = {analog[15:0], paddle[7:0], 8'h00}
  - 2 = zero-extended spinner pos
  - 3 = {frame_count, 16'h0000}
- Slot 7, field 0 = {busy, overrun, 14'b0, frame_count}. A read of this location clears overrun in the same cycle the ack is issued. If overrun is set in the same cycle, set wins.
- Any other slot/field reads 0.
- busy is high from the cycle after the edge is detected through the SWAP cycle inclusive.

Optional Feature:
- Macro: INPUT_SNAPSHOT_CHANGE_IRQ_EN.
- When defined:
  - Adds output port change_irq (1 bit).
  - During CAPTURE, each slot's joystick is compared with the same slot in the active bank.
  - Any difference latches irq_pending. change_irq asserts on the SWAP cycle +1 and stays high until a read of slot 7 field 1, which returns {31'b0, irq_pending} and clears it.
  - Reset clears irq_pending.
- When undefined:
  - No port, no comparators.
  - Slot 7 field 1 reads 0.

Test Plan:
- Reset: assert reset mid-CAPTURE (idx = 3) → all outputs 0 immediately; after release, read slot 0 field 0 = 0 and frame_count = 0.
- Capture/swap: joystick0 = 0x0000_0015, paddle2 = 0x80, vblank edge → busy high for 7 cycles, frame_count = 1; slot 0 field 0 = 0x15, slot 2 field 1 = 0x0000_8000.
- Spinner: player 1 gets three toggle flips with deltas +5, +5, −3, then a vblank → slot 1 field 2 = 7. A further delta of −8 → next frame reads 0x0000_FFFF.
- Coherency: read slot 0 field 0 continuously while joystick0 changes 0x1→0x2 mid-CAPTURE → reads stay 0x1 until the ack following SWAP, then read 0x2; no ack in the SWAP-sampled cycle.
- Overrun: second vblank edge 3 cycles into CAPTURE → slot 7 field 0 bit 30 = 1; an immediate re-read returns bit 30 = 0; frame_count advances by 1 only.
- IRQ (macro defined): joystick3 bit 4 set before vblank → change_irq high after SWAP; slot 7 field 1 read returns 1 and change_irq drops the next cycle; identical next frame → no IRQ.
